// File: rtl/simon_pkg.sv
// Shared types and helpers for the parametrised Simon game controller.
// Tone codes above the key range select the win and loss sounds.
package simon_pkg;

   typedef enum logic [4:0] {
      S_IDLE, S_INIT, S_GEN,
      S_SADDR, S_SWAIT, S_SON, S_SOFF,
      S_IADDR, S_IWAIT, S_IPOLL, S_ION, S_IOFF,
      S_EON, S_EOFF, S_LON, S_LOFF, S_WON, S_WOFF
   } state_t;

   localparam int TONE_W = 4;

   typedef struct packed {
      logic              play;
      logic [TONE_W-1:0] code;
   } tone_t;

   // Index width that never collapses to zero bits.
   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [TONE_W-1:0] tone_win(input int num_keys);
      return TONE_W'(num_keys);
   endfunction

   function automatic logic [TONE_W-1:0] tone_loss(input int num_keys);
      return TONE_W'(num_keys + 1);
   endfunction

endpackage

// File: rtl/simon_game_param_tone.sv
// Square-wave tone generator: the code selects a half period in clock cycles,
// and dropping play silences the output and clears the divider.
module simon_tone_gen
   import simon_pkg::*;
#(
   parameter int NUM_KEYS = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              play,
   input  logic [TONE_W-1:0] code,
   output logic              speaker
);

   logic [TONE_W-1:0] half;
   logic [TONE_W-1:0] div;

   always_comb begin
      half = TONE_W'(2);
      if (code < TONE_W'(NUM_KEYS))
         half = code + TONE_W'(3);
      else if (code == tone_win(NUM_KEYS))
         half = TONE_W'(NUM_KEYS + 3);
   end

   // '>=' keeps the divider sane if the code changes mid-period.
   always_ff @(posedge clock) begin
      if (!reset_n || !play) begin
         div     <= '0;
         speaker <= 1'b0;
      end else if (div >= half - TONE_W'(1)) begin
         div     <= '0;
         speaker <= ~speaker;
      end else begin
         div <= div + TONE_W'(1);
      end
   end

endmodule

// File: rtl/simon_game_param.sv
// Simon memory-sequence game controller: shows a growing random key sequence,
// checks the player's echo, and blinks win/loss patterns with audio.
module simon_game_param
   import simon_pkg::*;
#(
   parameter int NUM_KEYS  = 4,
   parameter int SEQ_DEPTH = 32,
   parameter int CNT_W     = 6,
   parameter int COUNT_SEQ = 33,
   parameter int COUNT_KEY = 33,
   parameter int COUNT_FIN = 8,
   parameter int DEC_SEQ   = 1,
   parameter int MIN_TB    = 4,
   parameter int RETRIES   = 2
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic                         mode,
   input  logic [NUM_KEYS-1:0]          k,
   output logic                         nloss,
   output logic [NUM_KEYS-1:0]          nl,
   output logic                         speaker,
   output logic [$clog2(SEQ_DEPTH):0]   score,
   output logic                         busy
);

   localparam int KW = width_of(NUM_KEYS);
   localparam int AW = $clog2(SEQ_DEPTH);
   localparam int SW = AW + 1;
   localparam int TW = width_of(RETRIES + 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [CNT_W-1:0]    tb_q, tb_d;
   logic [AW-1:0]       scan_q, scan_d;
   logic [AW-1:0]       max_q, max_d;
   logic [SW-1:0]       score_q, score_d;
   logic [TW-1:0]       tries_q, tries_d;
   logic                practice_q, practice_d;
   logic                nloss_q, nloss_d;
   logic [NUM_KEYS-1:0] nl_q, nl_d;
   tone_t               tone_q, tone_d;
   logic [KW-1:0]       rnd_q;
   logic [KW-1:0]       rdata_q;
   logic [KW-1:0]       mem [SEQ_DEPTH];
   logic                wr_en;

   logic                key_hit;
   logic [KW-1:0]       key_idx;
   logic [NUM_KEYS-1:0] exp_mask, key_mask;
   logic                cnt_zero;

   // Free-running key picker; the player's timing supplies the randomness.
   always_ff @(posedge clock) begin
      if (!reset_n)
         rnd_q <= '0;
      else if (rnd_q == KW'(NUM_KEYS - 1))
         rnd_q <= '0;
      else
         rnd_q <= rnd_q + KW'(1);
   end

   always_ff @(posedge clock) begin
      if (wr_en)
         mem[max_q] <= rnd_q;
      rdata_q <= mem[scan_q];
   end

   always_comb begin
      key_hit = |k;
      key_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--)
         if (k[i]) key_idx = KW'(i);
   end

   assign exp_mask = NUM_KEYS'(1) << rdata_q;
   assign key_mask = NUM_KEYS'(1) << key_idx;
   assign cnt_zero = (count_q == '0);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      tb_d       = tb_q;
      scan_d     = scan_q;
      max_d      = max_q;
      score_d    = score_q;
      tries_d    = tries_q;
      practice_d = practice_q;
      nloss_d    = nloss_q;
      nl_d       = nl_q;
      tone_d     = tone_q;
      wr_en      = 1'b0;

      case (state_q)
         S_IDLE: ;
         S_INIT: begin
            nloss_d    = 1'b0;
            nl_d       = '0;
            tone_d     = '0;
            score_d    = '0;
            max_d      = '0;
            tb_d       = CNT_W'(COUNT_SEQ);
            tries_d    = TW'(RETRIES);
            practice_d = mode;
            state_d    = S_GEN;
         end
         S_GEN: begin
            wr_en   = 1'b1;
            scan_d  = '0;
            state_d = S_SADDR;
         end
         S_SADDR: state_d = S_SWAIT;
         S_SWAIT: begin
            nl_d    = exp_mask;
            tone_d  = '{play: 1'b1, code: TONE_W'(rdata_q)};
            count_d = tb_q;
            state_d = S_SON;
         end
         S_SON, S_ION, S_EON: begin
            if (cnt_zero) begin
               nl_d        = '0;
               tone_d.play = 1'b0;
               count_d     = tb_q;
               state_d     = (state_q == S_SON) ? S_SOFF :
                             (state_q == S_ION) ? S_IOFF : S_EOFF;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         S_SOFF: begin
            if (!cnt_zero)
               count_d = count_q - CNT_W'(1);
            else if (scan_q != max_q) begin
               scan_d  = scan_q + AW'(1);
               state_d = S_SADDR;
            end else begin
               scan_d  = '0;
               state_d = S_IADDR;
            end
         end
         S_IADDR: state_d = S_IWAIT;
         S_IWAIT: begin
            count_d = CNT_W'(COUNT_KEY);
            state_d = S_IPOLL;
         end
         S_IPOLL: begin
            if (key_hit) begin
               nl_d    = key_mask;
               count_d = tb_q;
               if (key_idx == rdata_q) begin
                  tone_d  = '{play: 1'b1, code: TONE_W'(key_idx)};
                  state_d = S_ION;
               end else begin
                  tone_d  = '{play: 1'b1, code: tone_loss(NUM_KEYS)};
                  state_d = S_EON;
               end
            end else if (cnt_zero) begin
               // Timeout miss: no key to light, loss tone only.
               nl_d    = '0;
               tone_d  = '{play: 1'b1, code: tone_loss(NUM_KEYS)};
               count_d = tb_q;
               state_d = S_EON;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         S_IOFF: begin
            if (!cnt_zero)
               count_d = count_q - CNT_W'(1);
            else if (scan_q != max_q) begin
               scan_d  = scan_q + AW'(1);
               state_d = S_IADDR;
            end else if (max_q != AW'(SEQ_DEPTH - 1)) begin
               max_d   = max_q + AW'(1);
               score_d = score_q + SW'(1);
               tb_d    = (tb_q >= CNT_W'(MIN_TB + DEC_SEQ)) ? tb_q - CNT_W'(DEC_SEQ)
                                                            : CNT_W'(MIN_TB);
               state_d = S_GEN;
            end else begin
               score_d = score_q + SW'(1);
               nl_d    = '1;
               tone_d  = '{play: 1'b1, code: tone_win(NUM_KEYS)};
               count_d = CNT_W'(COUNT_FIN);
               state_d = S_WON;
            end
         end
         S_EOFF: begin
            if (!cnt_zero)
               count_d = count_q - CNT_W'(1);
            else if (practice_q && tries_q != '0) begin
               tries_d = tries_q - TW'(1);
               scan_d  = '0;
               state_d = S_SADDR;
            end else begin
               nloss_d = 1'b1;
               nl_d    = exp_mask;
               tone_d  = '{play: 1'b1, code: tone_loss(NUM_KEYS)};
               count_d = CNT_W'(COUNT_FIN);
               state_d = S_LON;
            end
         end
         S_LON, S_WON: begin
            if (cnt_zero) begin
               nl_d        = '0;
               tone_d.play = 1'b0;
               count_d     = CNT_W'(COUNT_FIN);
               state_d     = (state_q == S_LON) ? S_LOFF : S_WOFF;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         S_LOFF: begin
            if (cnt_zero) begin
               nl_d    = exp_mask;
               tone_d  = '{play: 1'b1, code: tone_loss(NUM_KEYS)};
               count_d = CNT_W'(COUNT_FIN);
               state_d = S_LON;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         S_WOFF: begin
            if (cnt_zero) begin
               nl_d    = '1;
               tone_d  = '{play: 1'b1, code: tone_win(NUM_KEYS)};
               count_d = CNT_W'(COUNT_FIN);
               state_d = S_WON;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // start aborts anything in flight and blanks the panel immediately.
      if (start) begin
         state_d     = S_INIT;
         nl_d        = '0;
         tone_d.play = 1'b0;
         score_d     = '0;
         nloss_d     = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         tb_q       <= '0;
         scan_q     <= '0;
         max_q      <= '0;
         score_q    <= '0;
         tries_q    <= '0;
         practice_q <= 1'b0;
         nloss_q    <= 1'b0;
         nl_q       <= '0;
         tone_q     <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         tb_q       <= tb_d;
         scan_q     <= scan_d;
         max_q      <= max_d;
         score_q    <= score_d;
         tries_q    <= tries_d;
         practice_q <= practice_d;
         nloss_q    <= nloss_d;
         nl_q       <= nl_d;
         tone_q     <= tone_d;
      end
   end

   simon_tone_gen #(.NUM_KEYS(NUM_KEYS)) u_tone (
      .clock   (clock),
      .reset_n (reset_n),
      .play    (tone_q.play),
      .code    (tone_q.code),
      .speaker (speaker)
   );

   assign nloss = nloss_q;
   assign nl    = nl_q;
   assign score = score_q;
   assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_simon_game_param.sv
// Directed bench for simon_game_param with a 4-key, depth-4 configuration.
module tb_simon_game_param;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       mode = 1'b0;
   logic [3:0] k = 4'b0;
   logic       nloss;
   logic [3:0] nl;
   logic       speaker;
   logic [2:0] score;
   logic       busy;

   int tests = 0;
   int fails = 0;
   int seq [4];

   always #5 clock = ~clock;

   simon_game_param #(
      .NUM_KEYS(4), .SEQ_DEPTH(4), .CNT_W(6), .COUNT_SEQ(33), .COUNT_KEY(33),
      .COUNT_FIN(8), .DEC_SEQ(1), .MIN_TB(4), .RETRIES(2)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .mode(mode), .k(k),
      .nloss(nloss), .nl(nl), .speaker(speaker), .score(score), .busy(busy)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int idx_of(input logic [3:0] v);
      for (int i = 0; i < 4; i++)
         if (v[i]) return i;
      return -1;
   endfunction

   task automatic wait_on(input string tag);
      int n = 0;
      while (nl == 4'b0 && n < 300) begin tick(); n++; end
      chk(tag, 32'(nl != 4'b0), 32'd1);
   endtask

   task automatic wait_off(input string tag);
      int n = 0;
      while (nl != 4'b0 && n < 300) begin tick(); n++; end
      chk(tag, 32'(nl == 4'b0), 32'd1);
   endtask

   task automatic wait_loss(output int n);
      n = 0;
      while (!nloss && n < 400) begin tick(); n++; end
   endtask

   // Returns the lit key and how many cycles it stayed lit.
   task automatic show_key(input string tag, output int key, output int len);
      wait_on(tag);
      key = idx_of(nl);
      chk("show_onehot", 32'($onehot(nl)), 32'd1);
      len = 0;
      while (nl != 4'b0 && len < 300) begin tick(); len++; end
   endtask

   // Reset with start held so the first generated key is always 2.
   task automatic new_game(input logic m);
      reset_n = 1'b0; start = 1'b1; mode = m; k = 4'b0;
      tick(); tick();
      reset_n = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic play_round(input int r, input int tb_exp);
      int key, len;
      for (int j = 0; j < r; j++) begin
         show_key("show_wait", key, len);
         if (j == 0) chk("score_before_round", 32'(score), 32'(r - 1));
         chk("show_len", 32'(len), 32'(tb_exp + 1));
         if (j < r - 1) chk("show_prefix", 32'(key), 32'(seq[j]));
         else seq[j] = key;
      end
      for (int j = 0; j < r; j++) begin
         k = 4'b0001 << seq[j];
         wait_on("echo_wait");
         chk("echo_led", 32'(nl), 32'(k));
         k = 4'b0;
         wait_off("echo_off");
      end
   endtask

   initial begin
      int n, m, key, len;

      // reset beats start
      reset_n = 1'b0; start = 1'b1;
      tick(); tick();
      chk("rst_nloss", 32'(nloss), 32'd0);
      chk("rst_nl", 32'(nl), 32'd0);
      chk("rst_speaker", 32'(speaker), 32'd0);
      chk("rst_score", 32'(score), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1; start = 1'b0;
      tick(); tick();
      chk("idle_after_release", 32'(busy), 32'd0);

      // win path: tb 33,32,31,30
      new_game(1'b0);
      chk("init_busy", 32'(busy), 32'd1);
      play_round(1, 33);
      chk("first_key", 32'(seq[0]), 32'd2);
      play_round(2, 32);
      play_round(3, 31);
      play_round(4, 30);
      wait_on("won_wait");
      chk("won_nl", 32'(nl), 32'hF);
      chk("won_score", 32'(score), 32'd4);
      chk("won_nloss", 32'(nloss), 32'd0);

      // abort during round 3 show
      new_game(1'b0);
      play_round(1, 33);
      play_round(2, 32);
      wait_on("abort_show");
      chk("abort_score_pre", 32'(score), 32'd2);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("abort_nl", 32'(nl), 32'd0);
      chk("abort_score", 32'(score), 32'd0);
      chk("abort_busy", 32'(busy), 32'd1);
      tick();
      chk("abort_speaker", 32'(speaker), 32'd0);

      // normal miss, tone timing, loss blink
      new_game(1'b0);
      wait_on("miss_show");
      chk("miss_shown_key", 32'(nl), 32'b0100);
      n = 0;
      while (!speaker && n < 20) begin tick(); n++; end
      chk("tone2_first_edge", 32'(n), 32'd5);
      m = 0;
      while (speaker && m < 20) begin tick(); m++; end
      chk("tone2_half_period", 32'(m), 32'd5);
      wait_off("miss_show_off");
      k = 4'b0001;
      wait_on("miss_eon");
      chk("miss_eon_led", 32'(nl), 32'b0001);
      chk("miss_eon_nloss", 32'(nloss), 32'd0);
      k = 4'b0;
      wait_loss(n);
      chk("miss_loss_delay", 32'(n), 32'd68);
      chk("lon_led", 32'(nl), 32'b0100);
      tick();
      chk("loss_tone_lo", 32'(speaker), 32'd0);
      tick();
      chk("loss_tone_hi", 32'(speaker), 32'd1);
      repeat (6) tick();
      chk("lon_last", 32'(nl), 32'b0100);
      tick();
      chk("loff_led", 32'(nl), 32'd0);
      chk("loff_nloss", 32'(nloss), 32'd1);

      // timeout miss: IPOLL lasts COUNT_KEY+1 cycles
      new_game(1'b0);
      show_key("to_show", key, len);
      chk("to_key", 32'(key), 32'd2);
      wait_loss(n);
      chk("timeout_loss_delay", 32'(n), 32'd138);

      // practice: two replays, third miss loses; k=1010 takes key 1
      new_game(1'b1);
      show_key("pr_show0", key, len);
      chk("pr_key0", 32'(key), 32'd2);
      k = 4'b1010;
      wait_on("pr_miss1");
      chk("priority_led", 32'(nl), 32'b0010);
      k = 4'b0;
      wait_off("pr_miss1_off");
      show_key("pr_replay1", key, len);
      chk("pr_replay1_key", 32'(key), 32'd2);
      chk("pr_replay1_nloss", 32'(nloss), 32'd0);
      k = 4'b0001;
      wait_on("pr_miss2");
      chk("pr_miss2_led", 32'(nl), 32'b0001);
      k = 4'b0;
      wait_off("pr_miss2_off");
      show_key("pr_replay2", key, len);
      chk("pr_replay2_key", 32'(key), 32'd2);
      chk("pr_replay2_nloss", 32'(nloss), 32'd0);
      k = 4'b0001;
      wait_on("pr_miss3");
      k = 4'b0;
      wait_loss(n);
      chk("pr_final_nloss", 32'(nloss), 32'd1);
      chk("pr_final_lon", 32'(nl), 32'b0100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
